// File: rtl/srt_r4_div_ctrl.sv
// Radix-4 SRT unsigned divider controller: exact digit selection over {-2..2},
// partial-remainder recurrence, on-the-fly quotient and final sign correction.
module srt_r4_div_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [WIDTH-1:0]        dividend,
   input  logic [WIDTH-1:0]        divisor,
   output logic                    busy,
   output logic                    done,
   output logic [WIDTH-1:0]        quotient,
   output logic [WIDTH-1:0]        remainder,
   output logic                    div_by_zero,
   output logic signed [2:0]       q_digit
);
   localparam int ITERS = WIDTH/2 + 1;
   localparam int REM_W = 2*WIDTH + 5;
   localparam int CMP_W = REM_W + 4;
   localparam int Q_W   = WIDTH + 3;
   localparam int CNT_W = $clog2(ITERS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_CORR = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Exact selection: 3w is compared against D and 4D, so no truncated estimate is needed.
   function automatic logic signed [2:0] sel_digit(
      input logic signed [CMP_W-1:0] w3,
      input logic signed [CMP_W-1:0] d1,
      input logic signed [CMP_W-1:0] d4
   );
      if (w3 >= d4)       sel_digit = 3'sb010;
      else if (w3 >= d1)  sel_digit = 3'sb001;
      else if (w3 > -d1)  sel_digit = 3'sb000;
      else if (w3 > -d4)  sel_digit = 3'sb111;
      else                sel_digit = 3'sb110;
   endfunction

   function automatic logic signed [CMP_W-1:0] digit_mult(
      input logic signed [2:0]       q,
      input logic signed [CMP_W-1:0] d1
   );
      case (q)
         3'sb010: digit_mult = d1 <<< 1;
         3'sb001: digit_mult = d1;
         3'sb111: digit_mult = -d1;
         3'sb110: digit_mult = -(d1 <<< 1);
         default: digit_mult = '0;
      endcase
   endfunction

   state_t                   state_q, state_d;
   logic signed [REM_W-1:0]  rem_q, rem_d;
   logic signed [REM_W-1:0]  dvs_q, dvs_d;
   logic signed [Q_W-1:0]    qacc_q, qacc_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [WIDTH-1:0]         quotient_q, quotient_d;
   logic [WIDTH-1:0]         remainder_q, remainder_d;
   logic                     dbz_q, dbz_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;

   logic signed [CMP_W-1:0]  w_ext;
   logic signed [CMP_W-1:0]  w3_ext;
   logic signed [CMP_W-1:0]  d1_ext;
   logic signed [CMP_W-1:0]  d4_ext;
   logic signed [2:0]        q_sel;
   logic signed [REM_W-1:0]  rs;
   logic signed [REM_W-1:0]  d_small;

   always_comb begin
      w_ext   = {{(CMP_W-REM_W){rem_q[REM_W-1]}}, rem_q} <<< 2;
      w3_ext  = w_ext + (w_ext <<< 1);
      d1_ext  = {{(CMP_W-REM_W){1'b0}}, dvs_q};
      d4_ext  = d1_ext <<< 2;
      q_sel   = sel_digit(w3_ext, d1_ext, d4_ext);
      rs      = rem_q >>> (WIDTH+2);
      d_small = dvs_q >>> (WIDTH+2);
      q_digit = (state_q == S_ITER) ? q_sel : 3'sb000;
   end

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      dvs_d       = dvs_q;
      qacc_d      = qacc_q;
      cnt_d       = cnt_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (divisor == '0) begin
                  quotient_d  = '1;
                  remainder_d = dividend;
                  dbz_d       = 1'b1;
                  state_d     = S_DONE;
               end else begin
                  dvs_d   = {{(REM_W-2*WIDTH-2){1'b0}}, divisor, {(WIDTH+2){1'b0}}};
                  rem_d   = {{(REM_W-WIDTH){1'b0}}, dividend};
                  qacc_d  = '0;
                  cnt_d   = '0;
                  state_d = S_ITER;
               end
            end
         end
         S_ITER: begin
            rem_d  = REM_W'(w_ext - digit_mult(q_sel, d1_ext));
            qacc_d = (qacc_q <<< 2) + Q_W'(q_sel);
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(ITERS-1)) state_d = S_CORR;
         end
         S_CORR: begin
            // Negative final remainder means the redundant quotient overshot by one.
            if (rs < 0) begin
               quotient_d  = WIDTH'(qacc_q - Q_W'(1));
               remainder_d = WIDTH'(rs + d_small);
            end else begin
               quotient_d  = WIDTH'(qacc_q);
               remainder_d = WIDTH'(rs);
            end
            dbz_d   = 1'b0;
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rem_q       <= '0;
         dvs_q       <= '0;
         qacc_q      <= '0;
         cnt_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         dvs_q       <= dvs_d;
         qacc_q      <= qacc_d;
         cnt_q       <= cnt_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_srt_r4_div_ctrl.sv
// Scoreboard bench for srt_r4_div_ctrl: stimulus pushes expected results, a
// negedge monitor pops and compares on every done pulse.
module tb_srt_r4_div_ctrl;
   localparam int WIDTH = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [WIDTH-1:0]  dividend = '0;
   logic [WIDTH-1:0]  divisor = '0;
   logic              busy;
   logic              done;
   logic [WIDTH-1:0]  quotient;
   logic [WIDTH-1:0]  remainder;
   logic              div_by_zero;
   logic signed [2:0] q_digit;

   srt_r4_div_ctrl #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .q_digit     (q_digit)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] r;
      logic             z;
      int               at;
   } exp_t;

   exp_t   sb[$];
   int     n_checks = 0;
   int     n_fail = 0;
   bit     mon_en = 1'b0;
   exp_t   me;
   int     qd;
   longint rv;
   longint dv;

   task automatic check(input string name, input longint act, input longint req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: digit range, idle digit, remainder bound and result scoreboard.
   always @(negedge clk) begin
      if (mon_en) begin
         qd = int'(q_digit);
         check("q_digit_range", longint'(qd >= -2 && qd <= 2), 1);
         if (!busy) check("q_digit_idle", longint'(qd), 0);
         if (dut.state_q == 2'd1) begin
            rv = longint'(dut.rem_q);
            dv = longint'(dut.dvs_q);
            if (rv < 0) rv = -rv;
            check("rem_bound", longint'(3*rv <= 2*dv), 1);
         end
         if (done) begin
            if (sb.size() == 0) begin
               check("spurious_done", 1, 0);
            end else begin
               me = sb.pop_front();
               check("done_cycle", longint'(cyc), longint'(me.at));
               check("quotient", longint'(quotient), longint'(me.q));
               check("remainder", longint'(remainder), longint'(me.r));
               check("div_by_zero", longint'(div_by_zero), longint'(me.z));
            end
         end
      end
   end

   task automatic wait_idle(input int exp_busy);
      int n;
      n = 0;
      while (busy && n < 40) begin
         n++;
         @(negedge clk);
      end
      check("busy_cycles", longint'(n), longint'(exp_busy));
   endtask

   task automatic push_exp(input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                           input logic ez, input int at);
      exp_t e;
      e.q = eq; e.r = er; e.z = ez; e.at = at;
      sb.push_back(e);
   endtask

   task automatic do_div(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] d,
                         input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                         input logic ez);
      int lat;
      lat = ez ? 1 : 7;
      push_exp(eq, er, ez, cyc + lat);
      dividend = x;
      divisor  = d;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle(lat);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual timeout required finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_busy", longint'(busy), 0);
      check("rst_done", longint'(done), 0);
      check("rst_quotient", longint'(quotient), 0);
      check("rst_remainder", longint'(remainder), 0);
      check("rst_dbz", longint'(div_by_zero), 0);
      check("rst_q_digit", longint'(q_digit), 0);
      rst_n = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;

      do_div(8'd100, 8'd7,   8'd14,  8'd2, 1'b0);
      do_div(8'd255, 8'd1,   8'd255, 8'd0, 1'b0);
      do_div(8'd0,   8'd200, 8'd0,   8'd0, 1'b0);
      do_div(8'd5,   8'd255, 8'd0,   8'd5, 1'b0);
      do_div(8'd255, 8'd255, 8'd1,   8'd0, 1'b0);
      do_div(8'd254, 8'd2,   8'd127, 8'd0, 1'b0);
      do_div(8'd128, 8'd3,   8'd42,  8'd2, 1'b0);
      do_div(8'd42,  8'd0,   8'hFF,  8'd42, 1'b1);
      do_div(8'd9,   8'd3,   8'd3,   8'd0, 1'b0);

      // A start pulse in the middle of a division is dropped.
      push_exp(8'd8, 8'd2, 1'b0, cyc + 7);
      dividend = 8'd50; divisor = 8'd6; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      dividend = 8'd200; divisor = 8'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle(4);

      // Start held high relaunches on the edge after DONE with the new operands.
      push_exp(8'd8, 8'd2, 1'b0, cyc + 7);
      push_exp(8'd8, 8'd5, 1'b0, cyc + 15);
      dividend = 8'd50; divisor = 8'd6; start = 1'b1;
      @(negedge clk);
      dividend = 8'd77; divisor = 8'd9;
      repeat (7) @(negedge clk);
      check("idle_gap_busy", longint'(busy), 0);
      @(negedge clk);
      start = 1'b0;
      wait_idle(7);

      // Reset in mid-division abandons it and clears the held results.
      dividend = 8'd100; divisor = 8'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_busy", longint'(busy), 0);
      check("midrst_done", longint'(done), 0);
      check("midrst_quotient", longint'(quotient), 0);
      check("midrst_remainder", longint'(remainder), 0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("post_rst_busy", longint'(busy), 0);
      do_div(8'd200, 8'd7, 8'd28, 8'd4, 1'b0);

      for (int x = 0; x < 256; x += 17) begin
         for (int d = 1; d < 256; d++) begin
            do_div(WIDTH'(x), WIDTH'(d), WIDTH'(x / d), WIDTH'(x % d), 1'b0);
         end
      end

      repeat (3) @(negedge clk);
      check("scoreboard_empty", longint'(sb.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
